reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the out-of-order LC-3b core.
- Allocates a tag per dispatched instruction and captures results broadcast on the CDB.
- Retires completed entries strictly in program order.
- Its commit outputs drive the downstream architectural register file write and the register-status table clear. Its flush input is the same mispredict flush that clears that table.

Parameters:
- data_width, 16, width of result data (lc3b_word).
- tag_width, 3, ROB tag width; depth = 2**tag_width = 8 entries.
- reg_width, 3, architectural register index width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- flush  input  1  mispredict flush; squashes every entry.
- alloc_req  input  1  dispatch requests an entry this cycle.
- alloc_has_dest  input  1  instruction writes a register.
- alloc_dest  input  reg_width  destination register.
- alloc_ready  output  1  buffer not full; an allocation is accepted only when alloc_req & alloc_ready.
- alloc_tag  output  tag_width  tag given to the accepted allocation (= tail pointer).
- cdb_valid  input  1  result broadcast valid.
- cdb_tag  input  tag_width  tag of broadcast result.
- cdb_data  input  data_width  broadcast value.
- rd_tag_a, rd_tag_b  input  tag_width  operand lookup tags.
- rd_done_a, rd_done_b  output  1  looked-up entry is valid and done.
- rd_data_a, rd_data_b  output  data_width  looked-up entry value.
- commit_valid  output  1  head entry retires this cycle.
- commit_has_dest  output  1  retiring entry writes a register.
- commit_dest  output  reg_width  retiring destination.
- commit_data  output  data_width  retiring value.
- commit_tag  output  tag_width  retiring tag (= head pointer).
- count  output  tag_width+1  occupied entries, 0..8.

Behaviour:
- State per entry: valid, done, has_dest, dest, data. Also head, tail, count registers.
- Reset values: all valid/done = 0; head = tail = 0; count = 0.
  - Resulting outputs: alloc_ready = 1, alloc_tag = 0, commit_valid = 0, rd_done_* = 0.
  - Data fields need not be cleared.
- Flush: identical effect to reset on the next edge. Reset has priority over flush; flush has priority over alloc, CDB and commit in the same cycle (all dropped).
- alloc_ready = (count != 8), from registered count only.
  - A commit in the same cycle does not free a slot for that cycle's allocation.
- Allocation (alloc_req & alloc_ready):
  - entry[tail] takes valid = 1, done = 0 and the alloc fields.
  - tail increments mod 8.
  - alloc_tag is combinational = tail.
- CDB (cdb_valid):
  - If entry[cdb_tag].valid, set done = 1 and data = cdb_data.
  - Writes to invalid entries are ignored.
  - A CDB write to an entry being allocated in the same cycle is ignored; allocation wins.
- Commit:
  - commit_valid = entry[head].valid & entry[head].done, combinational from registers.
  - commit_* fields are driven from entry[head].
  - On the edge: entry[head].valid = 0, done = 0, head increments mod 8.
  - At most one commit per cycle; the downstream stage always accepts it.
  - A CDB write to the head entry is visible as commit_valid on the following cycle (1-cycle result-to-commit latency).
- count update:
  - +1 on alloc only.
  - −1 on commit only.
  - Unchanged when both occur.
- Operand lookup:
  - Purely combinational from registered state.
  - No CDB bypass; the rename stage handles same-cycle CDB forwarding.
- Wrap-around: head and tail wrap 7→0. Full vs empty is distinguished by count, not pointer equality.

Decomposition:
- lc3b_types gains:
  - rob_tag typedef (logic [2:0]).
  - ROB_DEPTH constant = 8.
  - rob_entry packed struct {valid, done, has_dest, dest, data}.
- One sub-module, rob_ptr_ctrl: head/tail/count registers, full/empty, increment and wrap logic, reset/flush clearing.
- The entry array and lookup muxes stay in reorder_buffer.

Test Plan:
- Reset, then idle → alloc_ready = 1, alloc_tag = 0, count = 0, commit_valid = 0.
- Allocate 3 entries (R1, R2, R3) → tags 0, 1, 2. CDB tag1 = 0x0022, then tag0 = 0x0011.
  - Expect commit of tag 0 (R1, 0x0011) on the cycle after the tag0 broadcast.
  - Expect commit of tag 1 (R2, 0x0022) on the next cycle.
  - Expect tag 2 not committed until its CDB arrives.
- Allocate 8 entries → count = 8, alloc_ready = 0.
  - A ninth alloc_req is not accepted.
  - After one commit, alloc_ready = 1 and alloc_tag = 0 (wrap).
- CDB to tag 5 while entry 5 is invalid → no state change, rd_done for tag 5 = 0.
- With 4 entries live and tags 1–2 done, assert flush together with alloc_req and cdb_valid → next cycle count = 0, head = tail = 0, commit_valid = 0, no entry valid.
- Store with alloc_has_dest = 0 reaches head done → commit_valid = 1, commit_has_dest = 0, head advances.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the out-of-order core, including the reorder buffer
// tag, depth and entry layout.
package lc3b_types;

  localparam int DATA_WIDTH = 16;
  localparam int TAG_WIDTH  = 3;
  localparam int REG_WIDTH  = 3;
  localparam int ROB_DEPTH  = 8;

  typedef logic [DATA_WIDTH-1:0] lc3b_word;
  typedef logic [REG_WIDTH-1:0]  lc3b_reg;
  typedef logic [TAG_WIDTH-1:0]  rob_tag;

  typedef struct packed {
    logic     valid;
    logic     done;
    logic     has_dest;
    lc3b_reg  dest;
    lc3b_word data;
  } rob_entry;

endpackage

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer. Full and empty are
// decided by the occupancy count, because head == tail is ambiguous.
module rob_ptr_ctrl #(
  parameter int tag_width = 3
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_alloc_req,
  input  logic                 i_commit_req,
  output logic [tag_width-1:0] o_head,
  output logic [tag_width-1:0] o_tail,
  output logic [tag_width:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_alloc_fire,
  output logic                 o_commit_fire
);

  localparam int DEPTH = 2 ** tag_width;
  localparam logic [tag_width:0] FULL_COUNT = DEPTH[tag_width:0];

  logic [tag_width-1:0] r_head;
  logic [tag_width-1:0] r_tail;
  logic [tag_width:0]   r_count;

  // Fullness comes from the registered count only, so a same-cycle commit
  // never opens a slot for that cycle's allocation.
  assign o_full        = (r_count == FULL_COUNT);
  assign o_empty       = (r_count == '0);
  assign o_alloc_fire  = i_alloc_req & ~o_full & ~i_flush;
  assign o_commit_fire = i_commit_req & ~i_flush;

  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (i_reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Pointers are exactly tag_width bits wide, so +1 wraps 7 -> 0 by itself.
      if (o_alloc_fire)  r_tail <= r_tail + 1'b1;
      if (o_commit_fire) r_head <= r_head + 1'b1;
      case ({o_alloc_fire, o_commit_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at dispatch, captures CDB results
// and retires the head entry once its result has arrived.
module reorder_buffer
  import lc3b_types::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int tag_width  = TAG_WIDTH,
  parameter int reg_width  = REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  alloc_req,
  input  logic                  alloc_has_dest,
  input  logic [reg_width-1:0]  alloc_dest,
  output logic                  alloc_ready,
  output logic [tag_width-1:0]  alloc_tag,
  input  logic                  cdb_valid,
  input  logic [tag_width-1:0]  cdb_tag,
  input  logic [data_width-1:0] cdb_data,
  input  logic [tag_width-1:0]  rd_tag_a,
  input  logic [tag_width-1:0]  rd_tag_b,
  output logic                  rd_done_a,
  output logic                  rd_done_b,
  output logic [data_width-1:0] rd_data_a,
  output logic [data_width-1:0] rd_data_b,
  output logic                  commit_valid,
  output logic                  commit_has_dest,
  output logic [reg_width-1:0]  commit_dest,
  output logic [data_width-1:0] commit_data,
  output logic [tag_width-1:0]  commit_tag,
  output logic [tag_width:0]    count
);

  localparam int DEPTH = 2 ** tag_width;

  logic                  r_valid    [DEPTH];
  logic                  r_done     [DEPTH];
  logic                  r_has_dest [DEPTH];
  logic [reg_width-1:0]  r_dest     [DEPTH];
  logic [data_width-1:0] r_data     [DEPTH];

  logic [tag_width-1:0] w_head;
  logic [tag_width-1:0] w_tail;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_alloc_fire;
  logic                 w_commit_fire;

  rob_ptr_ctrl #(
    .tag_width (tag_width)
  ) u_ptr_ctrl (
    .clk           (clk),
    .i_reset       (reset),
    .i_flush       (flush),
    .i_alloc_req   (alloc_req),
    .i_commit_req  (commit_valid),
    .o_head        (w_head),
    .o_tail        (w_tail),
    .o_count       (count),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_alloc_fire  (w_alloc_fire),
    .o_commit_fire (w_commit_fire)
  );

  assign alloc_ready = ~w_full;
  assign alloc_tag   = w_tail;

  assign commit_valid    = r_valid[w_head] & r_done[w_head];
  assign commit_has_dest = r_has_dest[w_head];
  assign commit_dest     = r_dest[w_head];
  assign commit_data     = r_data[w_head];
  assign commit_tag      = w_head;

  // No CDB bypass here: rename forwards same-cycle broadcasts itself.
  assign rd_done_a = r_valid[rd_tag_a] & r_done[rd_tag_a];
  assign rd_done_b = r_valid[rd_tag_b] & r_done[rd_tag_b];
  assign rd_data_a = r_data[rd_tag_a];
  assign rd_data_b = r_data[rd_tag_b];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [tag_width-1:0] IDX = gi[tag_width-1:0];

      logic w_alloc_hit;
      logic w_commit_hit;
      logic w_cdb_hit;

      assign w_alloc_hit  = w_alloc_fire & (w_tail == IDX);
      assign w_commit_hit = w_commit_fire & (w_head == IDX);
      // A broadcast to a slot being re-allocated this cycle is stale; drop it.
      assign w_cdb_hit    = cdb_valid & ~flush & (cdb_tag == IDX) &
                            r_valid[gi] & ~w_alloc_hit;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          r_valid[gi] <= 1'b0;
          r_done[gi]  <= 1'b0;
        end else if (w_alloc_hit) begin
          r_valid[gi]    <= 1'b1;
          r_done[gi]     <= 1'b0;
          r_has_dest[gi] <= alloc_has_dest;
          r_dest[gi]     <= alloc_dest;
        end else if (w_commit_hit) begin
          r_valid[gi] <= 1'b0;
          r_done[gi]  <= 1'b0;
        end else if (w_cdb_hit) begin
          r_done[gi] <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (w_cdb_hit && !reset) begin
          r_data[gi] <= cdb_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reorder_buffer.sv
// Random and directed stimulus for reorder_buffer, checked against a
// program-order queue model of the in-flight instructions.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, alloc_req, alloc_has_dest, cdb_valid;
  logic [2:0]  alloc_dest, cdb_tag, rd_tag_a, rd_tag_b;
  logic [15:0] cdb_data;
  logic        alloc_ready, rd_done_a, rd_done_b, commit_valid, commit_has_dest;
  logic [2:0]  alloc_tag, commit_dest, commit_tag;
  logic [15:0] rd_data_a, rd_data_b, commit_data;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  int n_steps  = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_req(alloc_req), .alloc_has_dest(alloc_has_dest), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
    .rd_done_a(rd_done_a), .rd_done_b(rd_done_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
    .commit_dest(commit_dest), .commit_data(commit_data), .commit_tag(commit_tag),
    .count(count)
  );

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [2:0]  tag;
    logic        has_dest;
    logic [2:0]  dest;
    logic        done;
    logic [15:0] data;
  } inst_t;

  inst_t q[$];
  int    next_tag = 0;
  bit    model_known = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (step %0d)", tag, obs, exp, n_steps);
    end
  endtask

  function automatic int find_tag(input logic [2:0] t);
    for (int i = 0; i < q.size(); i++)
      if (q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic check_lookup(input string nm, input logic [2:0] t,
                              input logic done_obs, input logic [15:0] data_obs);
    int  k;
    logic exp_done;
    k = find_tag(t);
    exp_done = (k >= 0) ? q[k].done : 1'b0;
    check({nm, "_done"}, 32'(done_obs), 32'(exp_done));
    if (exp_done) check({nm, "_data"}, 32'(data_obs), 32'(q[k].data));
  endtask

  task automatic check_outputs();
    logic exp_commit;
    exp_commit = (q.size() > 0) && q[0].done;
    check("alloc_ready", 32'(alloc_ready), 32'(q.size() != 8));
    check("alloc_tag", 32'(alloc_tag), 32'(next_tag));
    check("count", 32'(count), 32'(q.size()));
    check("commit_valid", 32'(commit_valid), 32'(exp_commit));
    if (exp_commit) begin
      check("commit_tag", 32'(commit_tag), 32'(q[0].tag));
      check("commit_has_dest", 32'(commit_has_dest), 32'(q[0].has_dest));
      if (q[0].has_dest) check("commit_dest", 32'(commit_dest), 32'(q[0].dest));
      check("commit_data", 32'(commit_data), 32'(q[0].data));
    end
    check_lookup("rd_a", rd_tag_a, rd_done_a, rd_data_a);
    check_lookup("rd_b", rd_tag_b, rd_done_b, rd_data_b);
  endtask

  task automatic update_model();
    bit   do_commit;
    int   k;
    if (reset || flush) begin
      q.delete();
      next_tag = 0;
      model_known = 1;
      return;
    end
    do_commit = (q.size() > 0) && q[0].done;
    if (cdb_valid) begin
      k = find_tag(cdb_tag);
      if (k >= 0) begin
        q[k].done = 1'b1;
        q[k].data = cdb_data;
      end
    end
    if (do_commit) void'(q.pop_front());
    if (alloc_req && (q.size() + (do_commit ? 1 : 0)) != 8) begin
      q.push_back('{tag: 3'(next_tag), has_dest: alloc_has_dest, dest: alloc_dest,
                    done: 1'b0, data: 16'h0});
      next_tag = (next_tag + 1) % 8;
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic areq, input logic ahd,
                      input logic [2:0] adest, input logic cv, input logic [2:0] ctag,
                      input logic [15:0] cdata);
    @(negedge clk);
    reset = rst; flush = fl; alloc_req = areq; alloc_has_dest = ahd; alloc_dest = adest;
    cdb_valid = cv; cdb_tag = ctag; cdb_data = cdata;
    rd_tag_a = 3'($urandom_range(0, 7)); rd_tag_b = 3'($urandom_range(0, 7));
    #1;
    if (model_known) check_outputs();
    $display("step %0d rst=%0b fl=%0b alloc=%0b/%0d cdb=%0b/%0d:%04h count=%0d commit=%0b tag=%0d",
             n_steps, rst, fl, areq, alloc_tag, cv, ctag, cdata, count, commit_valid, commit_tag);
    @(posedge clk);
    update_model();
    n_steps++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 3'd0, 0, 3'd0, 16'h0);
  endtask

  task automatic alloc(input logic ahd, input logic [2:0] d);
    step(0, 0, 1, ahd, d, 0, 3'd0, 16'h0);
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] v);
    step(0, 0, 0, 0, 3'd0, 1, t, v);
  endtask

  initial begin
    // Reset and idle
    step(1, 0, 0, 0, 3'd0, 0, 3'd0, 16'h0);
    idle();

    // Out-of-order completion, in-order retirement
    alloc(1, 3'd1); alloc(1, 3'd2); alloc(1, 3'd3);
    cdb(3'd1, 16'h0022);
    cdb(3'd0, 16'h0011);
    idle(); idle(); idle();
    cdb(3'd2, 16'h0033);
    idle(); idle();

    // Fill to eight, refused ninth, wrap after one commit
    step(1, 0, 0, 0, 3'd0, 0, 3'd0, 16'h0);
    for (int i = 0; i < 8; i++) alloc(1, 3'(i));
    alloc(1, 3'd7);
    cdb(3'd0, 16'hbeef);
    idle();
    alloc(1, 3'd5);
    idle();

    // Broadcast to an empty slot is ignored
    step(1, 0, 0, 0, 3'd0, 0, 3'd0, 16'h0);
    cdb(3'd5, 16'h5555);
    idle();

    // Flush beats alloc and CDB in the same cycle
    for (int i = 0; i < 4; i++) alloc(1, 3'(i));
    cdb(3'd1, 16'h0101);
    cdb(3'd2, 16'h0202);
    step(0, 1, 1, 1, 3'd4, 1, 3'd3, 16'h0303);
    idle(); idle();

    // Store without a destination retires
    alloc(0, 3'd0);
    cdb(3'd0, 16'h7777);
    idle(); idle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6), 1'($urandom), 3'($urandom),
           ($urandom_range(0, 9) < 7), 3'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
